fnd_sum_display: RTL and testbench
==================================

// Module: fnd_sum_display
// PURPOSE
//  Downstream display stage for the 8-bit adder: takes {c_out,sum} (0..510), converts it to
//  4 decimal digits and time-multiplexes them onto a 4-digit common-anode 7-segment (FND).
//  Contains a tick divider, 2-bit digit scan counter, frame-synchronous operand capture
//  and registered segment/common outputs. Sits between full_adder8 and board FND pins.
// PARAMETERS
//  DIV_COUNT  100_000  clk cycles per digit slot (100 MHz -> 1 kHz digit rate); >= 2
// PORTS
//  clk       in   1  system clock, single clock domain
//  reset     in   1  asynchronous, active-high reset
//  sum       in   8  adder sum, unsigned
//  c_out     in   1  adder carry out, weight 256
//  fnd_com   out  4  digit enables, active-low one-hot; bit0 = ones digit
//  fnd_data  out  8  segments, active-low {dp,g,f,e,d,c,b,a}
// BEHAVIOUR
//  - Reset (async, active-high): div_cnt=0, sel=0, val_q=0, fnd_com=4'b1111,
//    fnd_data=8'hFF. Outputs forced immediately on reset, independent of clk.
//  - Divider: div_cnt counts 0..DIV_COUNT-1 then wraps to 0; tick=1 for one clk when
//    div_cnt==DIV_COUNT-1.
//  - Scan: sel (2 bits) increments on tick, wraps 3->0. No other state changes sel.
//  - Capture: val_q (9 bits) <= {c_out,sum} on the clk where tick && sel==3, i.e. at
//    the frame boundary only. Inputs are ignored at all other times -> no digit tearing.
//    First frame after reset shows 0000 regardless of inputs.
//  - Width: value = {c_out,sum}, 9-bit unsigned, 0..510; no saturation needed.
//    d0=val%10, d1=(val/10)%10, d2=(val/100)%10, d3=val/1000 (always 0). No blanking.
//  - Decode (per digit, 0..9): C0,F9,A4,B0,99,92,82,F8,80,90 hex; codes 10..15 -> FF.
//    dp (bit7) always 1 (off).
//  - Outputs registered: fnd_com <= ~(4'b0001<<sel), fnd_data <= seg(d[sel]); i.e. one clk
//    after sel changes. Each digit held exactly DIV_COUNT clks; frame = 4*DIV_COUNT clks.
//  - Latency input -> display: up to one frame + 2 clks (capture at boundary, then register).
//  - Reset mid-frame: scan restarts at sel=0, captured value cleared to 0.
//  - Exactly one fnd_com bit low at all times outside reset; never two digits on.
// STRUCTURE
//  - Shared package fnd_pkg: 7-seg code localparams SEG_0..SEG_9, SEG_OFF=8'hFF,
//    COM_OFF=4'b1111, digit-rate default DIV_COUNT.
//  - One sub-module: fnd_decoder (4-bit BCD in -> 8-bit active-low seg out, combinational).
//  - Top holds divider, scan counter, capture register, BCD split, output registers.
// TESTING (sim with DIV_COUNT=4)
//  1 reset=1 any inputs -> fnd_com=4'b1111, fnd_data=8'hFF; release with sum=255 -> first
//    frame shows 0000 (C0 on all digits), com sequence 1110,1101,1011,0111, 4 clks each.
//  2 sum=8'd255,c_out=0 held 2 frames -> second frame: 1110/92, 1101/92, 1011/A4, 0111/C0.
//  3 sum=8'hFE,c_out=1 (510) -> 1110/C0, 1101/F9, 1011/92, 0111/C0; then sum=0,c_out=0
//    -> all C0 next frame.
//  4 Change sum 123->45 while sel=1 -> digits 1..3 of current frame still show 123
//    (A4 on 1101, F9 on 1011); next frame shows 45 (92,99,C0,C0).
//  5 Assert reset during sel=2 (async, between clk edges) -> outputs F/FF same time step;
//    after release scan restarts at 1110, div_cnt from 0.
//  6 Free-run 100 frames with random sum/c_out at boundaries -> scoreboard every digit vs
//    decimal model; assert one-hot-low fnd_com every clk outside reset.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit common-anode 7-segment display path.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package fnd_pkg;
  localparam int FND_DIV_COUNT = 100_000;

  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] COM_OFF = 4'b1111;
endpackage

// File: rtl/fnd_decoder.sv
// BCD digit to active-low 7-segment code; non-decimal codes blank the digit.
module fnd_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);
  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/fnd_sum_display.sv
// Shows {c_out,sum} as four decimal digits on a multiplexed common-anode FND.
// The operand is sampled only at the frame boundary so a frame never mixes two values.
module fnd_sum_display
  import fnd_pkg::*;
#(
  parameter int DIV_COUNT = FND_DIV_COUNT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sum,
  input  logic       c_out,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);
  localparam int DW = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_COUNT - 1);

  logic [DW-1:0]   div_cnt;
  logic [1:0]      sel;
  logic [8:0]      val_q;
  logic            tick;
  logic [3:0][3:0] dig;
  logic [3:0][7:0] seg_all;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sel     <= '0;
      val_q   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        sel <= sel + 2'd1;
        if (sel == 2'd3) val_q <= {c_out, sum};
      end
    end
  end

  // Max value is 510, so the thousands digit is structurally zero.
  always_comb begin
    dig[0] = 4'(val_q % 9'd10);
    dig[1] = 4'((val_q / 9'd10) % 9'd10);
    dig[2] = 4'((val_q / 9'd100) % 9'd10);
    dig[3] = 4'd0;
  end

  for (genvar i = 0; i < 4; i++) begin : g_dec
    fnd_decoder u_dec (
      .bcd (dig[i]),
      .seg (seg_all[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fnd_com  <= COM_OFF;
      fnd_data <= SEG_OFF;
    end else begin
      fnd_com  <= ~(4'b0001 << sel);
      fnd_data <= seg_all[sel];
    end
  end
endmodule

// File: tb/tb_fnd_sum_display.sv
// Directed frame-by-frame check of the FND scan with DIV_COUNT=4 (16-clk frames).
module tb_fnd_sum_display;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sum;
  logic       c_out;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic armed;

  fnd_sum_display #(.DIV_COUNT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sum      (sum),
    .c_out    (c_out),
    .fnd_com  (fnd_com),
    .fnd_data (fnd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      sum;
    logic            c_out;
    logic [3:0][7:0] seg;   // {d3,d2,d1,d0}
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; 9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0][7:0] dec(input int v);
    logic [3:0][7:0] r;
    r[0] = seg_of(v % 10);
    r[1] = seg_of((v / 10) % 10);
    r[2] = seg_of((v / 100) % 10);
    r[3] = seg_of(v / 1000);
    return r;
  endfunction

  // Checks the 16 output samples of one frame; optionally changes inputs at sample chg_at.
  task automatic run_frame(input logic [3:0][7:0] exp, input string name,
                           input int chg_at, input logic [8:0] chg_v);
    logic [3:0] ec;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ec = ~(4'b0001 << (k / 4));
      chk($sformatf("%s com d%0d c%0d", name, k / 4, k % 4), 32'(fnd_com), 32'(ec));
      chk($sformatf("%s seg d%0d c%0d", name, k / 4, k % 4), 32'(fnd_data), 32'(exp[k / 4]));
      if (k == chg_at) {c_out, sum} = chg_v;
    end
  endtask

  // Exactly one digit enabled on every clock once the scan has produced its first output.
  always @(posedge clk or posedge reset)
    if (reset) armed <= 1'b0;
    else       armed <= 1'b1;

  always @(negedge clk)
    if (armed && !reset)
      chk("onehot com", 32'($countones(~fnd_com)), 32'd1);

  initial begin
    logic [3:0][7:0] prev;
    logic [3:0][7:0] c0s;
    logic [8:0] v, pv;

    c0s = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
    vecs[0] = '{8'd255, 1'b0, {8'hC0, 8'hA4, 8'h92, 8'h92}};
    vecs[1] = '{8'hFE,  1'b1, {8'hC0, 8'h92, 8'hF9, 8'hC0}};
    vecs[2] = '{8'd0,   1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vecs[3] = '{8'd123, 1'b0, {8'hC0, 8'hF9, 8'hA4, 8'hB0}};
    vecs[4] = '{8'd45,  1'b0, {8'hC0, 8'hC0, 8'h99, 8'h92}};
    vecs[5] = '{8'd9,   1'b0, {8'hC0, 8'hC0, 8'hC0, 8'h90}};
    vecs[6] = '{8'd100, 1'b0, {8'hC0, 8'hF9, 8'hC0, 8'hC0}};
    vecs[7] = '{8'd0,   1'b1, {8'hC0, 8'hA4, 8'h92, 8'h82}};
    vecs[8] = '{8'd78,  1'b0, {8'hC0, 8'hC0, 8'hF8, 8'h80}};

    // Reset state with live inputs
    reset = 1'b1; sum = 8'd255; c_out = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset com", 32'(fnd_com), 32'hF);
    chk("reset seg", 32'(fnd_data), 32'hFF);
    reset = 1'b0;

    // First frame shows 0000 despite sum=255, then 255
    run_frame(c0s, "first", -1, 9'd0);
    run_frame(vecs[0].seg, "hold255", -1, 9'd0);

    // Table: each vector is displayed on the frame after the one it is applied in
    prev = vecs[0].seg;
    for (int i = 0; i < 9; i++) begin
      sum = vecs[i].sum; c_out = vecs[i].c_out;
      run_frame(prev, $sformatf("vec%0d", i), -1, 9'd0);
      prev = vecs[i].seg;
    end
    run_frame(prev, "vec_last", -1, 9'd0);

    // Mid-frame change 123 -> 45 must not tear the current frame
    sum = 8'd123; c_out = 1'b0;
    run_frame(prev, "pre123", -1, 9'd0);
    run_frame(vecs[3].seg, "tear123", 5, 9'd45);
    run_frame(vecs[4].seg, "show45", -1, 9'd0);

    // Async reset while digit 2 is scanned
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async com", 32'(fnd_com), 32'hF);
    chk("async seg", 32'(fnd_data), 32'hFF);
    @(negedge clk);
    chk("inreset com", 32'(fnd_com), 32'hF);
    reset = 1'b0;
    sum = 8'd255; c_out = 1'b0;
    run_frame(c0s, "post_rst", -1, 9'd0);
    run_frame(vecs[0].seg, "post_rst255", -1, 9'd0);

    // Random free-run against the decimal model
    pv = 9'd255;
    for (int f = 0; f < 100; f++) begin
      v = 9'($urandom_range(0, 510));
      {c_out, sum} = v;
      run_frame(dec(int'(pv)), $sformatf("rnd%0d", f), -1, 9'd0);
      pv = v;
    end
    run_frame(dec(int'(pv)), "rnd_last", -1, 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
